// File: rtl/ovport_sched.sv
// Per-output-port scheduler: captures IPG words addressed to OVPORT_ADR, buffers them per input, and sends whole messages by class then round-robin.
// Latency 3 cycles from input word to tx_ipg_en; oversize messages are truncated and messages that do not fit are refused (drop_pulse), with no upstream backpressure.

module ovport_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    assign head    = mem[rptr];
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_dat;
    end
endmodule

module ovport_sched #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADR_WIDTH     = 40,
    parameter int NUM_PORTS     = 4,
    parameter int OVPORT_ADR    = 0,
    parameter int FIFO_DEPTH    = 8,
    parameter int MAX_MSG_WORDS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              iv_ipg_en,
    input  logic [NUM_PORTS*ADR_WIDTH/2-1:0]  src_flat,
    input  logic [NUM_PORTS*ADR_WIDTH/2-1:0]  dst_flat,
    input  logic [NUM_PORTS-1:0]              wreq_valid,
    input  logic [NUM_PORTS-1:0]              rreq_valid,
    input  logic [NUM_PORTS-1:0]              rresp_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   fwd_ipg_data_flat,
    output logic                              tx_ipg_en,
    output logic [DATA_WIDTH-1:0]             tx_ipg_data,
    output logic [NUM_PORTS-1:0]              drop_pulse
);
    localparam int AH = ADR_WIDTH / 2;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(MAX_MSG_WORDS + 2);
    localparam int EW = DATA_WIDTH + 3;
    localparam int QW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [NUM_PORTS-1:0] match, push, pop, empty;
    logic [EW-1:0]        push_dat [NUM_PORTS];
    logic [EW-1:0]        head     [NUM_PORTS];
    logic [QW-1:0]        fifo_cnt [NUM_PORTS];

    // Source address plays no part in scheduling.
    logic unused_src;
    assign unused_src = ^src_flat;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        logic [AH-1:0]         dst;
        logic [1:0]            cls_now, cls_lat, stage_cls;
        logic                  prev_match, admitted, stage_vld, stage_force, drop_q, room;
        logic [CW-1:0]         cnt;
        logic [DATA_WIDTH-1:0] stage_dat;

        assign dst      = dst_flat[i*AH +: AH];
        assign match[i] = iv_ipg_en[i] && (dst == AH'(OVPORT_ADR)) &&
                          (wreq_valid[i] || rreq_valid[i] || rresp_valid[i]);
        assign cls_now  = rresp_valid[i] ? 2'd2 : (rreq_valid[i] ? 2'd1 : 2'd0);
        assign room     = (fifo_cnt[i] <= QW'(FIFO_DEPTH - MAX_MSG_WORDS));

        // prev_match keeps tracking through reset so the tail of an interrupted message is not taken as a new one.
        always_ff @(posedge clk) begin
            if (rst) begin
                prev_match  <= match[i];
                admitted    <= 1'b0;
                cnt         <= '0;
                cls_lat     <= '0;
                stage_vld   <= 1'b0;
                stage_dat   <= '0;
                stage_cls   <= '0;
                stage_force <= 1'b0;
                drop_q      <= 1'b0;
            end else begin
                prev_match <= match[i];
                drop_q     <= 1'b0;
                stage_vld  <= 1'b0;
                if (match[i]) begin
                    if (!prev_match) begin
                        cls_lat <= cls_now;
                        if (room) begin
                            admitted    <= 1'b1;
                            cnt         <= CW'(1);
                            stage_vld   <= 1'b1;
                            stage_dat   <= fwd_ipg_data_flat[i*DATA_WIDTH +: DATA_WIDTH];
                            stage_cls   <= cls_now;
                            stage_force <= (MAX_MSG_WORDS == 1);
                        end else begin
                            admitted <= 1'b0;
                            drop_q   <= 1'b1;
                        end
                    end else if (admitted) begin
                        if (cnt < CW'(MAX_MSG_WORDS)) begin
                            cnt         <= cnt + CW'(1);
                            stage_vld   <= 1'b1;
                            stage_dat   <= fwd_ipg_data_flat[i*DATA_WIDTH +: DATA_WIDTH];
                            stage_cls   <= cls_lat;
                            stage_force <= (cnt == CW'(MAX_MSG_WORDS - 1));
                        end else if (cnt == CW'(MAX_MSG_WORDS)) begin
                            cnt    <= cnt + CW'(1);
                            drop_q <= 1'b1;
                        end
                    end
                end
            end
        end

        assign push[i]       = stage_vld;
        assign push_dat[i]   = {stage_cls, stage_force | ~match[i], stage_dat};
        assign drop_pulse[i] = drop_q;

        ovport_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push[i]),
            .push_dat (push_dat[i]),
            .pop      (pop[i]),
            .head     (head[i]),
            .empty    (empty[i]),
            .count    (fifo_cnt[i])
        );
    end

    state_t        state;
    logic [PW-1:0] grant, rr_ptr, sel_idx, scan;
    logic [1:0]    sel_cls;
    logic          sel_vld;

    // Strict '>' keeps the first candidate met from rr_ptr among equal classes.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        sel_cls = '0;
        scan    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan = (int'(rr_ptr) + k >= NUM_PORTS) ? PW'(int'(rr_ptr) + k - NUM_PORTS)
                                                   : PW'(int'(rr_ptr) + k);
            if (!empty[scan] && (!sel_vld || head[scan][EW-1 -: 2] > sel_cls)) begin
                sel_vld = 1'b1;
                sel_idx = scan;
                sel_cls = head[scan][EW-1 -: 2];
            end
        end
    end

    assign pop = (state == SEND && !empty[grant]) ? (NUM_PORTS'(1) << grant) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            tx_ipg_en   <= 1'b0;
            tx_ipg_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_ipg_en <= 1'b0;
                    if (sel_vld) begin
                        grant <= sel_idx;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (!empty[grant]) begin
                        tx_ipg_en   <= 1'b1;
                        tx_ipg_data <= head[grant][DATA_WIDTH-1:0];
                        if (head[grant][DATA_WIDTH]) begin
                            rr_ptr <= (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + PW'(1);
                            state  <= IDLE;
                        end
                    end else begin
                        tx_ipg_en <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ovport_sched.sv
// Directed bench for ovport_sched serving port 2: single, incast, priority, filter, limits and reset scenarios.
module tb_ovport_sched;
    localparam int DW = 64;
    localparam int AH = 20;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    iv_ipg_en, wreq_valid, rreq_valid, rresp_valid;
    logic [NP*AH-1:0] src_flat, dst_flat;
    logic [NP*DW-1:0] fwd_ipg_data_flat;
    logic             tx_ipg_en;
    logic [DW-1:0]    tx_ipg_data;
    logic [NP-1:0]    drop_pulse;

    int checks   = 0;
    int failures = 0;

    ovport_sched #(
        .DATA_WIDTH(64), .ADR_WIDTH(40), .NUM_PORTS(4),
        .OVPORT_ADR(2), .FIFO_DEPTH(8), .MAX_MSG_WORDS(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .iv_ipg_en         (iv_ipg_en),
        .src_flat          (src_flat),
        .dst_flat          (dst_flat),
        .wreq_valid        (wreq_valid),
        .rreq_valid        (rreq_valid),
        .rresp_valid       (rresp_valid),
        .fwd_ipg_data_flat (fwd_ipg_data_flat),
        .tx_ipg_en         (tx_ipg_en),
        .tx_ipg_data       (tx_ipg_data),
        .drop_pulse        (drop_pulse)
    );

    function automatic logic [63:0] wd(input int p, input int m, input int w);
        return 64'hA5A5_0000_0000_0000 | (64'(p) << 16) | (64'(m) << 8) | 64'(w);
    endfunction

    task automatic clr();
        iv_ipg_en = '0; wreq_valid = '0; rreq_valid = '0; rresp_valid = '0;
        src_flat = '0; dst_flat = '0; fwd_ipg_data_flat = '0;
    endtask

    // kind: 0 wreq, 1 rreq, 2 rresp, 3 no valid
    task automatic put(input int p, input int dst, input int kind, input logic [63:0] d);
        iv_ipg_en[p]               = 1'b1;
        dst_flat[p*AH +: AH]       = AH'(dst);
        src_flat[p*AH +: AH]       = AH'(p);
        wreq_valid[p]              = (kind == 0);
        rreq_valid[p]              = (kind == 1);
        rresp_valid[p]             = (kind == 2);
        fwd_ipg_data_flat[p*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clr();
        rst = 1'b1;
        for (int p = 0; p < NP; p++) put(p, 2, 1, wd(p, 9, 0));
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (tx_ipg_en !== 1'b0 || tx_ipg_data !== 64'd0 || drop_pulse !== 4'd0) begin
                failures++;
                $display("FAIL reset_outputs t=%0d got en=%b dat=%h drop=%b want 0/0/0", t, tx_ipg_en, tx_ipg_data, drop_pulse);
            end
        end
        rst = 1'b0;
        clr();
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if (tx_ipg_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle t=%0d got en=%b want 0", t, tx_ipg_en);
            end
        end
    endtask

    task automatic test_single();
        logic exp_en;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            clr();
            if (t < 3) put(0, 2, 1, wd(0, 0, t));
            tick();
            exp_en = (t >= 3 && t <= 5);
            checks++;
            if (tx_ipg_en !== exp_en) begin
                failures++;
                $display("FAIL single_en t=%0d got %b want %b", t, tx_ipg_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (tx_ipg_data !== wd(0, 0, t - 3)) begin
                    failures++;
                    $display("FAIL single_dat t=%0d got %h want %h", t, tx_ipg_data, wd(0, 0, t - 3));
                end
            end
            checks++;
            if (drop_pulse !== 4'd0) begin
                failures++;
                $display("FAIL single_drop t=%0d got %b want 0000", t, drop_pulse);
            end
        end
    endtask

    // Second round after the first proves rr_ptr wrapped back to 0.
    task automatic test_incast();
        logic        exp_en;
        logic [63:0] exp_dat;
        int          u, r;
        do_reset();
        for (int t = 0; t < 26; t++) begin
            u = t % 13;
            r = t / 13;
            clr();
            if (u < 3) begin
                put(0, 2, 1, wd(0, r, u));
                put(3, 2, 1, wd(3, r, u));
            end
            tick();
            exp_en  = (u >= 3 && u <= 5) || (u >= 7 && u <= 9);
            exp_dat = (u <= 5) ? wd(0, r, u - 3) : wd(3, r, u - 7);
            checks++;
            if (tx_ipg_en !== exp_en) begin
                failures++;
                $display("FAIL incast_en t=%0d got %b want %b", t, tx_ipg_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (tx_ipg_data !== exp_dat) begin
                    failures++;
                    $display("FAIL incast_dat t=%0d got %h want %h", t, tx_ipg_data, exp_dat);
                end
            end
        end
    endtask

    task automatic test_priority();
        logic        exp_en;
        logic [63:0] exp_dat;
        do_reset();
        for (int t = 0; t < 11; t++) begin
            clr();
            if (t < 2) begin
                put(1, 2, 0, wd(1, 0, t));
                put(2, 2, 2, wd(2, 0, t));
            end
            tick();
            exp_en  = (t == 3 || t == 4 || t == 6 || t == 7);
            exp_dat = (t <= 4) ? wd(2, 0, t - 3) : wd(1, 0, t - 6);
            checks++;
            if (tx_ipg_en !== exp_en) begin
                failures++;
                $display("FAIL prio_en t=%0d got %b want %b", t, tx_ipg_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (tx_ipg_data !== exp_dat) begin
                    failures++;
                    $display("FAIL prio_dat t=%0d got %h want %h", t, tx_ipg_data, exp_dat);
                end
            end
        end
    endtask

    task automatic test_filter();
        do_reset();
        for (int t = 0; t < 10; t++) begin
            clr();
            if (t < 3) begin
                put(0, 1, 1, wd(0, 0, t));
                put(1, 2, 2, wd(1, 0, t));
                wreq_valid[1] = 1'b1;
                rreq_valid[1] = 1'b1;
                iv_ipg_en[1]  = 1'b0;
                put(2, 2, 3, wd(2, 0, t));
            end
            tick();
            checks++;
            if (tx_ipg_en !== 1'b0 || drop_pulse !== 4'd0) begin
                failures++;
                $display("FAIL filter t=%0d got en=%b drop=%b want 0/0000", t, tx_ipg_en, drop_pulse);
            end
        end
    endtask

    task automatic test_limits();
        logic        exp_en;
        logic [63:0] exp_dat;
        int          ndrop;
        // 6-word message: 4 words out, one drop pulse.
        do_reset();
        ndrop = 0;
        for (int t = 0; t < 11; t++) begin
            clr();
            if (t < 6) put(0, 2, 1, wd(0, 0, t));
            tick();
            ndrop += int'(drop_pulse[0]);
            exp_en = (t >= 3 && t <= 6);
            checks++;
            if (tx_ipg_en !== exp_en) begin
                failures++;
                $display("FAIL trunc_en t=%0d got %b want %b", t, tx_ipg_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (tx_ipg_data !== wd(0, 0, t - 3)) begin
                    failures++;
                    $display("FAIL trunc_dat t=%0d got %h want %h", t, tx_ipg_data, wd(0, 0, t - 3));
                end
            end
        end
        checks++;
        if (ndrop != 1) begin
            failures++;
            $display("FAIL trunc_drop_count got %0d want 1", ndrop);
        end

        // Ports 1-3 rresp traffic holds port0's FIFO at 5 words when its third message arrives.
        do_reset();
        ndrop = 0;
        for (int t = 0; t < 31; t++) begin
            clr();
            if (t < 4) begin
                put(0, 2, 0, wd(0, 1, t));
                put(1, 2, 2, wd(1, 0, t));
                put(2, 2, 2, wd(2, 0, t));
                put(3, 2, 2, wd(3, 0, t));
            end
            if (t == 5) put(0, 2, 0, wd(0, 2, 0));
            if (t == 7 || t == 8) put(0, 2, 0, wd(0, 3, t - 7));
            tick();
            ndrop += int'(drop_pulse[0]);
            exp_en  = 1'b1;
            exp_dat = '0;
            if (t >= 3 && t <= 6)        exp_dat = wd(1, 0, t - 3);
            else if (t >= 8 && t <= 11)  exp_dat = wd(2, 0, t - 8);
            else if (t >= 13 && t <= 16) exp_dat = wd(3, 0, t - 13);
            else if (t >= 18 && t <= 21) exp_dat = wd(0, 1, t - 18);
            else if (t == 23)            exp_dat = wd(0, 2, 0);
            else                         exp_en  = 1'b0;
            checks++;
            if (tx_ipg_en !== exp_en) begin
                failures++;
                $display("FAIL refuse_en t=%0d got %b want %b", t, tx_ipg_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (tx_ipg_data !== exp_dat) begin
                    failures++;
                    $display("FAIL refuse_dat t=%0d got %h want %h", t, tx_ipg_data, exp_dat);
                end
            end
            checks++;
            if (drop_pulse[3:1] !== 3'b000) begin
                failures++;
                $display("FAIL refuse_other_drop t=%0d got %b want 000", t, drop_pulse[3:1]);
            end
        end
        checks++;
        if (ndrop != 1) begin
            failures++;
            $display("FAIL refuse_drop_count got %0d want 1", ndrop);
        end
    endtask

    task automatic test_reset_mid();
        logic exp_en;
        // Reset while the message is still arriving.
        do_reset();
        for (int t = 0; t < 10; t++) begin
            clr();
            rst = (t == 1);
            if (t < 3) put(0, 2, 1, wd(0, 4, t));
            tick();
            checks++;
            if (tx_ipg_en !== 1'b0 || drop_pulse !== 4'd0) begin
                failures++;
                $display("FAIL rstin t=%0d got en=%b drop=%b want 0/0000", t, tx_ipg_en, drop_pulse);
            end
        end
        // Reset while the message is being sent.
        do_reset();
        for (int t = 0; t < 10; t++) begin
            clr();
            rst = (t == 4);
            if (t < 3) put(0, 2, 1, wd(0, 5, t));
            tick();
            exp_en = (t == 3);
            checks++;
            if (tx_ipg_en !== exp_en) begin
                failures++;
                $display("FAIL rstout_en t=%0d got %b want %b", t, tx_ipg_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (tx_ipg_data !== wd(0, 5, 0)) begin
                    failures++;
                    $display("FAIL rstout_dat t=%0d got %h want %h", t, tx_ipg_data, wd(0, 5, 0));
                end
            end
        end
        rst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            clr();
            if (t < 3) put(0, 2, 1, wd(0, 6, t));
            tick();
            exp_en = (t >= 3 && t <= 5);
            checks++;
            if (tx_ipg_en !== exp_en) begin
                failures++;
                $display("FAIL rstafter_en t=%0d got %b want %b", t, tx_ipg_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (tx_ipg_data !== wd(0, 6, t - 3)) begin
                    failures++;
                    $display("FAIL rstafter_dat t=%0d got %h want %h", t, tx_ipg_data, wd(0, 6, t - 3));
                end
            end
        end
    endtask

    initial begin
        clr();
        test_reset();
        test_single();
        test_incast();
        test_priority();
        test_filter();
        test_limits();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
